bus_slave_regs: RTL and testbench

//  Generic bus slave responder: a word-wide register file with programmable wait states.
//  It sits behind one slave chip-select (sN_cs_) of the bus, accepts master reads and writes,
//  and drives sN_rd_data_/sN_rdy_ back to the slave-side read mux.

---
 rtl/bus_slave_regs_if.sv | 23 ++
 rtl/bus_slave_regs.sv | 120 ++++++++++++
 tb/tb_bus_slave_regs.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_regs_if.sv
// Bus connection between a master and one register-file slave. The strobes are active low.
// addr is a word address and rdy_ is a one-cycle ready pulse.
interface bus_slave_regs_if #(
  parameter int ADDR_W = 30
);
  logic              cs_;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );
endinterface

// File: rtl/bus_slave_regs.sv
// Word-wide register file behind one bus chip-select, with programmable wait states.
// Register 0 is also exported as a live control word.
module bus_slave_regs #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 30,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  bus_slave_regs_if.slave bus,
  output logic [31:0] reg0_out
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             rw_reg, rw_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic             rdy_reg, rdy_next;
  logic [31:0]      rd_data_reg, rd_data_next;
  logic             write_en;
  logic [31:0]      regs [NUM_REGS];

  // Upper address bits alias onto the register file; the upstream decoder owns the map.
  generate
    if (ADDR_W > IDX_W) begin : g_addr_unused
      logic unused_addr;
      assign unused_addr = ^bus.addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    rw_next      = rw_reg;
    wdata_next   = wdata_reg;
    rdy_next     = 1'b1;
    rd_data_next = 32'd0;
    write_en     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!bus.cs_ && !bus.as_) begin
          idx_next   = bus.addr[IDX_W-1:0];
          rw_next    = bus.rw;
          wdata_next = bus.wr_data;
          if (WAIT_CYCLES == 0) begin
            state_next   = S_ACK;
            rdy_next     = 1'b0;
            rd_data_next = bus.rw ? regs[bus.addr[IDX_W-1:0]] : 32'd0;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Losing chip-select mid-wait cancels the transaction silently.
        if (bus.cs_) begin
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd0) begin
          state_next   = S_ACK;
          rdy_next     = 1'b0;
          rd_data_next = rw_reg ? regs[idx_reg] : 32'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_ACK: begin
        state_next = S_IDLE;
        write_en   = !rw_reg;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= '0;
      rw_reg      <= 1'b0;
      wdata_reg   <= 32'd0;
      rdy_reg     <= 1'b1;
      rd_data_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      rw_reg      <= rw_next;
      wdata_reg   <= wdata_next;
      rdy_reg     <= rdy_next;
      rd_data_reg <= rd_data_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (write_en) begin
      regs[idx_reg] <= wdata_reg;
    end
  end

  assign bus.rdy_    = rdy_reg;
  assign bus.rd_data = rd_data_reg;
  assign reg0_out    = regs[0];
endmodule

// File: tb/tb_bus_slave_regs.sv
// Bench for bus_slave_regs: three instances (0, 1 and 3 wait states) are checked
// against an array model of register contents and the expected ready latency.
module tb_bus_slave_regs;
  logic clk;
  logic reset;

  logic        cs_d  [3];
  logic        as_d  [3];
  logic        rw_d  [3];
  logic [29:0] addr_d[3];
  logic [31:0] wd_d  [3];
  logic        rdy_o [3];
  logic [31:0] rdd_o [3];
  logic [31:0] r0_o  [3];

  logic [31:0] model [3][8];
  int checks = 0;
  int errors = 0;

  bus_slave_regs_if #(.ADDR_W(30)) if0();
  bus_slave_regs_if #(.ADDR_W(30)) if1();
  bus_slave_regs_if #(.ADDR_W(30)) if2();

  assign if0.cs_ = cs_d[0]; assign if0.as_ = as_d[0]; assign if0.rw = rw_d[0];
  assign if0.addr = addr_d[0]; assign if0.wr_data = wd_d[0];
  assign if1.cs_ = cs_d[1]; assign if1.as_ = as_d[1]; assign if1.rw = rw_d[1];
  assign if1.addr = addr_d[1]; assign if1.wr_data = wd_d[1];
  assign if2.cs_ = cs_d[2]; assign if2.as_ = as_d[2]; assign if2.rw = rw_d[2];
  assign if2.addr = addr_d[2]; assign if2.wr_data = wd_d[2];
  assign rdy_o[0] = if0.rdy_; assign rdd_o[0] = if0.rd_data;
  assign rdy_o[1] = if1.rdy_; assign rdd_o[1] = if1.rd_data;
  assign rdy_o[2] = if2.rdy_; assign rdd_o[2] = if2.rd_data;

  bus_slave_regs #(.NUM_REGS(8), .ADDR_W(30), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .reg0_out(r0_o[0]));
  bus_slave_regs #(.NUM_REGS(8), .ADDR_W(30), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .reg0_out(r0_o[1]));
  bus_slave_regs #(.NUM_REGS(8), .ADDR_W(30), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .bus(if2), .reg0_out(r0_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  // One master transaction on instance k. lat counts cycles after the accept edge
  // (1 = the cycle right after it), -1 if rdy_ never arrived within the budget.
  task automatic run_txn(input int k, input bit rw, input logic [29:0] addr,
                         input logic [31:0] data, input bit scramble,
                         output int lat, output logic [31:0] rdv,
                         output bit pulse_ok, output bit quiet_ok);
    lat = -1; rdv = 32'hx; pulse_ok = 1'b0; quiet_ok = 1'b1;
    @(negedge clk);
    cs_d[k] = 1'b0; as_d[k] = 1'b0; rw_d[k] = rw; addr_d[k] = addr; wd_d[k] = data;
    @(posedge clk); #1;
    if (scramble) begin
      wd_d[k] = $urandom; addr_d[k] = 30'($urandom); rw_d[k] = ~rw;
    end
    for (int c = 1; c <= 40; c++) begin
      if (rdy_o[k] === 1'b0) begin
        lat = c; rdv = rdd_o[k];
        break;
      end
      if (rdd_o[k] !== 32'd0) quiet_ok = 1'b0;
      @(posedge clk); #1;
    end
    cs_d[k] = 1'b1; as_d[k] = 1'b1;
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_ok = (rdy_o[k] === 1'b1) && (rdd_o[k] === 32'd0);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_o[k] !== 1'b1 || rdd_o[k] !== 32'd0 || r0_o[k] !== 32'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: rdy_=%b rd_data=%h reg0=%h, want 1/0/0",
                 k, rdy_o[k], rdd_o[k], r0_o[k]);
      end
    end
  endtask

  task automatic test_wait1_rw();
    int lat; logic [31:0] rdv; bit pok, qok;
    run_txn(1, 1'b0, 30'd3, 32'hDEADBEEF, 1'b0, lat, rdv, pok, qok);
    model[1][3] = 32'hDEADBEEF;
    checks++;
    if (lat !== 2 || !pok) begin
      errors++;
      $display("FAIL w1_write_latency: lat=%0d pulse_ok=%0b, want 2/1", lat, pok);
    end
    run_txn(1, 1'b1, 30'd3, 32'd0, 1'b0, lat, rdv, pok, qok);
    checks++;
    if (lat !== 2 || !pok || !qok || rdv !== model[1][3]) begin
      errors++;
      $display("FAIL w1_read: lat=%0d pulse=%0b quiet=%0b data=%h, want 2/1/1/%h",
               lat, pok, qok, rdv, model[1][3]);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rdv; bit pok, qok;
    run_txn(0, 1'b0, 30'd0, 32'h00000005, 1'b0, lat, rdv, pok, qok);
    model[0][0] = 32'h5;
    checks++;
    if (lat !== 1 || !pok || r0_o[0] !== 32'h5) begin
      errors++;
      $display("FAIL w0_write: lat=%0d pulse=%0b reg0=%h, want 1/1/00000005", lat, pok, r0_o[0]);
    end
    run_txn(0, 1'b1, 30'd0, 32'd0, 1'b0, lat, rdv, pok, qok);
    checks++;
    if (lat !== 1 || !pok || rdv !== 32'h5) begin
      errors++;
      $display("FAIL w0_read: lat=%0d pulse=%0b data=%h, want 1/1/00000005", lat, pok, rdv);
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rdv; bit pok, qok;
    bit seen_rdy;
    seen_rdy = 1'b0;
    @(negedge clk);
    cs_d[2] = 1'b0; as_d[2] = 1'b0; rw_d[2] = 1'b0; addr_d[2] = 30'd2; wd_d[2] = 32'h12345678;
    @(posedge clk); #1;
    if (rdy_o[2] !== 1'b1) seen_rdy = 1'b1;
    @(posedge clk); #1;
    if (rdy_o[2] !== 1'b1) seen_rdy = 1'b1;
    cs_d[2] = 1'b1; as_d[2] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdy_o[2] !== 1'b1) seen_rdy = 1'b1;
    end
    checks++;
    if (seen_rdy) begin
      errors++;
      $display("FAIL abort_no_rdy: rdy_ pulsed=1, want 0");
    end
    run_txn(2, 1'b1, 30'd2, 32'd0, 1'b0, lat, rdv, pok, qok);
    checks++;
    if (lat !== 4 || rdv !== model[2][2]) begin
      errors++;
      $display("FAIL abort_readback: lat=%0d data=%h, want 4/%h", lat, rdv, model[2][2]);
    end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rdv; bit pok, qok;
    run_txn(1, 1'b0, 30'h0000000D, 32'hA5A5A5A5, 1'b1, lat, rdv, pok, qok);
    model[1][5] = 32'hA5A5A5A5;
    checks++;
    if (lat !== 2 || rdv !== 32'd0) begin
      errors++;
      $display("FAIL alias_write: lat=%0d data=%h, want 2/00000000", lat, rdv);
    end
    run_txn(1, 1'b1, 30'd5, 32'd0, 1'b0, lat, rdv, pok, qok);
    checks++;
    if (rdv !== model[1][5]) begin
      errors++;
      $display("FAIL alias_read5: data=%h, want %h", rdv, model[1][5]);
    end
    run_txn(1, 1'b1, 30'h3FFFFFF5, 32'd0, 1'b0, lat, rdv, pok, qok);
    checks++;
    if (rdv !== model[1][5]) begin
      errors++;
      $display("FAIL alias_read_hi: data=%h, want %h", rdv, model[1][5]);
    end
  endtask

  task automatic test_idle_bus();
    int lat; logic [31:0] rdv; bit pok, qok;
    int bad;
    bad = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cs_d[k] = 1'b1; as_d[k] = 1'b0; rw_d[k] = 1'b0; addr_d[k] = 30'd1; wd_d[k] = 32'hFFFFFFFF;
    end
    repeat (20) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (rdy_o[k] !== 1'b1 || rdd_o[k] !== 32'd0) bad++;
    end
    for (int k = 0; k < 3; k++) as_d[k] = 1'b1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_bus_outputs: bad_samples=%0d, want 0", bad);
    end
    for (int k = 0; k < 3; k++) begin
      run_txn(k, 1'b1, 30'd1, 32'd0, 1'b0, lat, rdv, pok, qok);
      checks++;
      if (rdv !== model[k][1] || r0_o[k] !== model[k][0]) begin
        errors++;
        $display("FAIL idle_bus_regs dut%0d: reg1=%h reg0=%h, want %h/%h",
                 k, rdv, r0_o[k], model[k][1], model[k][0]);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rdv; bit pok, qok;
    bit rw; logic [29:0] a; logic [31:0] d, exp_d;
    for (int n = 0; n < 90; n++) begin
      int k;
      k = n % 3;
      rw = 1'($urandom_range(0, 1));
      a = 30'($urandom);
      d = $urandom;
      exp_d = rw ? model[k][a % 8] : 32'd0;
      run_txn(k, rw, a, d, 1'($urandom_range(0, 1)), lat, rdv, pok, qok);
      if (!rw) model[k][a % 8] = d;
      checks++;
      if (lat !== wc(k) + 1 || !pok || !qok || rdv !== exp_d || r0_o[k] !== model[k][0]) begin
        errors++;
        $display("FAIL random dut%0d rw=%0b addr=%h: lat=%0d pulse=%0b quiet=%0b data=%h reg0=%h, want %0d/1/1/%h/%h",
                 k, rw, a, lat, pok, qok, rdv, r0_o[k], wc(k) + 1, exp_d, model[k][0]);
      end
    end
  endtask

  task automatic test_reset_midwait();
    int lat; logic [31:0] rdv; bit pok, qok;
    run_txn(2, 1'b0, 30'd0, 32'hC0DE0001, 1'b0, lat, rdv, pok, qok);
    model[2][0] = 32'hC0DE0001;
    checks++;
    if (r0_o[2] !== 32'hC0DE0001) begin
      errors++;
      $display("FAIL pre_reset_reg0: reg0=%h, want c0de0001", r0_o[2]);
    end
    @(negedge clk);
    cs_d[2] = 1'b0; as_d[2] = 1'b0; rw_d[2] = 1'b1; addr_d[2] = 30'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_o[k] !== 1'b1 || rdd_o[k] !== 32'd0 || r0_o[k] !== 32'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d: rdy_=%b rd_data=%h reg0=%h, want 1/0/0",
                 k, rdy_o[k], rdd_o[k], r0_o[k]);
      end
      cs_d[k] = 1'b1; as_d[k] = 1'b1;
      for (int a = 0; a < 8; a++) model[k][a] = 32'd0;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 8; a++) begin
        run_txn(k, 1'b1, 30'(a), 32'd0, 1'b0, lat, rdv, pok, qok);
        checks++;
        if (lat !== wc(k) + 1 || rdv !== model[k][a]) begin
          errors++;
          $display("FAIL post_reset_read dut%0d addr%0d: lat=%0d data=%h, want %0d/%h",
                   k, a, lat, rdv, wc(k) + 1, model[k][a]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cs_d[k] = 1'b1; as_d[k] = 1'b1; rw_d[k] = 1'b1; addr_d[k] = '0; wd_d[k] = '0;
      for (int a = 0; a < 8; a++) model[k][a] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_wait1_rw();
    test_back_to_back();
    test_abort();
    test_alias();
    test_idle_bus();
    test_random();
    test_reset_midwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
